vliw_regfile: RTL and testbench
===============================

Name: vliw_regfile

Overview:
- Shared integer register file that serves the widened per-lane register ports driven by the LANES ieu instances of the VLIW core.
- Each lane supplies two read addresses (a1, a2) and one write port (we3, a3, wd3), and receives two read data values (rd1, rd2).
- Resolves same-cycle write collisions between lanes deterministically.
- Provides write-to-read bypass so that a Decode-stage read observes a same-cycle Writeback.
- Counts and flags collision events for debug and performance visibility.

Parameters:
- P, cvw_t, core configuration. Uses P.XLEN and P.E_SUPPORTED.
- LANES, 4, number of ieu lanes. Legal range 1..4. Lane index also sets write priority.
- BYPASS, 1, 1 enables write-through forwarding of same-cycle writes to reads.
- CNTW, 16, width of the collision counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- we3  in  [LANES-1:0]  per-lane write enable (Writeback)
- a3  in  [LANES-1:0][4:0]  per-lane destination register
- wd3  in  [LANES-1:0][P.XLEN-1:0]  per-lane write data
- a1, a2  in  [LANES-1:0][4:0]  per-lane source register addresses (Decode)
- rd1, rd2  out  [LANES-1:0][P.XLEN-1:0]  per-lane read data
- WriteCollisionM  out  1  registered pulse: previous cycle had at least one write collision
- CollisionSticky  out  1  set on any collision, cleared only by reset
- CollisionCount  out  [CNTW-1:0]  saturating count of collision cycles

Behaviour:
- Reset, synchronous, takes priority over writes:
  - All registers, WriteCollisionM, CollisionSticky and CollisionCount clear to 0 on the first posedge with reset high.
  - Writes presented in that cycle are dropped.
  - While reset is high, all rd outputs are forced to 0.
- NREGS = P.E_SUPPORTED ? 16 : 32. Addresses >= NREGS are illegal:
  - Writes to them are ignored and do not count as collisions.
  - Reads from them return 0.
- x0 is hardwired to 0:
  - Writes to a3 = 0 are ignored and never count as collisions.
  - Reads of x0 return 0, including under bypass.
- Write timing: state updates at posedge clk. A write is effective when we3[i]=1, a3[i]!=0 and a3[i]<NREGS.
- Collision resolution:
  - When two or more effective writes in one cycle target the same register, the highest lane index wins (latest slot in bundle order).
  - Losing writes are discarded.
  - A cycle containing at least one such conflict is a collision cycle.
- Read path is combinational, with zero cycles of latency from a1/a2:
  - BYPASS=1: if an effective write this cycle targets the read address, return the winning wd3 for that register. Otherwise return the stored value.
  - BYPASS=0: always return the stored value. A same-cycle write becomes visible on the next cycle.
- Collision bookkeeping, all updated at the posedge following a collision cycle:
  - WriteCollisionM <= collision cycle indicator (one-cycle pulse per collision cycle).
  - CollisionSticky <= 1.
  - CollisionCount increments by 1 per collision cycle, independent of how many registers conflicted. It saturates at all-ones with no wrap.
- Lanes are independent: any lane may read any register while any set of lanes writes. There is no stall or backpressure output.
- LANES=1: no collisions are possible, and the collision outputs remain 0.

Decomposition:
- The shared cvw package holds:
  - a VLIW_LANES constant (default 4);
  - a typedef regaddr_t (logic [4:0]).
- One sub-module, vliw_wr_arbiter:
  - Combinational priority resolution per register index.
  - Produces the per-register winning write enable and data, plus the collision flag.
  - Reused by both the storage write and the bypass mux.

Test Plan:
- Reset: hold reset for 2 cycles with we3=4'b1111, a3=5 and wd3=all ones on every lane -> after release, reading x5 from every lane returns 0, CollisionCount=0 and CollisionSticky=0.
- Basic write/read: lane 2 writes x7=0x1234 and x9 is written by lane 0 with 0xABCD. The next cycle, lane 3 reads a1=7, a2=9 -> rd1[3]=0x1234, rd2[3]=0xABCD. A read of x0 returns 0 after we3[1]=1, a3=0, wd3=0xFF.
- Bypass: BYPASS=1, with lane 1 writing x10=0x55 while lane 0 reads a1=10 in the same cycle -> rd1[0]=0x55 combinationally. With BYPASS=0 the same stimulus gives the old value, then 0x55 one cycle later.
- Collision: lanes 0, 1 and 3 all write x12 with 0x1, 0x2 and 0x3 in one cycle -> x12=0x3 and WriteCollisionM=1 for exactly one cycle. CollisionCount increments 0->1 and CollisionSticky stays 1 after further collision-free cycles.
- Saturation: CNTW=4 with 20 consecutive collision cycles -> CollisionCount holds at 4'hF.
- RV32E: P.E_SUPPORTED=1, write x20=0x99 -> no state change, rd of x20 returns 0, and no collision is counted even when two lanes target x20.

Source files
------------

// File: rtl/vliw_regfile_pkg.sv
// Shared configuration types and constants for the VLIW register file slice.
package vliw_regfile_pkg;

  localparam int unsigned VLIW_LANES = 4;

  typedef logic [4:0] regaddr_t;

  typedef struct packed {
    int unsigned XLEN;
    logic        E_SUPPORTED;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{XLEN: 32, E_SUPPORTED: 1'b0};

endpackage

// File: rtl/vliw_wr_arbiter.sv
// Per-register write arbitration across lanes: highest lane index wins,
// and any register hit by two or more lanes flags a collision.
module vliw_wr_arbiter
  import vliw_regfile_pkg::*;
#(
  parameter int unsigned LANES = VLIW_LANES,
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic [LANES-1:0]             we3,
  input  regaddr_t [LANES-1:0]         a3,
  input  logic [LANES-1:0][XLEN-1:0]   wd3,
  output logic [NREGS-1:1]             win_we,
  output logic [NREGS-1:1][XLEN-1:0]   win_wd,
  output logic                         collision
);

  // Only indices 1..NREGS-1 are scanned, so x0 and out-of-range
  // destinations never match and never collide.
  always_comb begin
    win_we    = '0;
    win_wd    = '0;
    collision = 1'b0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (we3[i] && a3[i] == regaddr_t'(r)) begin
          if (win_we[r]) collision = 1'b1;
          win_we[r] = 1'b1;
          win_wd[r] = wd3[i];
        end
      end
    end
  end

endmodule

// File: rtl/vliw_regfile.sv
// Multi-lane integer register file with deterministic write-collision
// resolution, optional same-cycle bypass and collision bookkeeping.
module vliw_regfile
  import vliw_regfile_pkg::*;
#(
  parameter cvw_t        P      = CVW_DEFAULT,
  parameter int unsigned LANES  = VLIW_LANES,
  parameter bit          BYPASS = 1'b1,
  parameter int unsigned CNTW   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES-1:0]             we3,
  input  logic [LANES-1:0][4:0]        a3,
  input  logic [LANES-1:0][P.XLEN-1:0] wd3,
  input  logic [LANES-1:0][4:0]        a1,
  input  logic [LANES-1:0][4:0]        a2,
  output logic [LANES-1:0][P.XLEN-1:0] rd1,
  output logic [LANES-1:0][P.XLEN-1:0] rd2,
  output logic                         WriteCollisionM,
  output logic                         CollisionSticky,
  output logic [CNTW-1:0]              CollisionCount
);

  localparam int unsigned XLEN  = P.XLEN;
  localparam int unsigned NREGS = P.E_SUPPORTED ? 16 : 32;

  logic [NREGS-1:1][XLEN-1:0] regs;
  logic [NREGS-1:1]           win_we;
  logic [NREGS-1:1][XLEN-1:0] win_wd;
  logic                       collision;

  vliw_wr_arbiter #(
    .LANES(LANES),
    .XLEN (XLEN),
    .NREGS(NREGS)
  ) u_arb (
    .we3      (we3),
    .a3       (a3),
    .wd3      (wd3),
    .win_we   (win_we),
    .win_wd   (win_wd),
    .collision(collision)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      regs            <= '0;
      WriteCollisionM <= 1'b0;
      CollisionSticky <= 1'b0;
      CollisionCount  <= '0;
    end else begin
      for (int unsigned r = 1; r < NREGS; r++)
        if (win_we[r]) regs[r] <= win_wd[r];
      WriteCollisionM <= collision;
      if (collision) begin
        CollisionSticky <= 1'b1;
        if (CollisionCount != '1) CollisionCount <= CollisionCount + CNTW'(1);
      end
    end
  end

  // x0 and illegal addresses fall through the scan and read as zero.
  function automatic logic [XLEN-1:0] read_port(input regaddr_t a);
    logic [XLEN-1:0] v;
    v = '0;
    for (int unsigned r = 1; r < NREGS; r++)
      if (a == regaddr_t'(r)) v = (BYPASS && win_we[r]) ? win_wd[r] : regs[r];
    return v;
  endfunction

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (!reset) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        rd1[i] = read_port(a1[i]);
        rd2[i] = read_port(a2[i]);
      end
    end
  end

endmodule

// File: tb/tb_vliw_regfile.sv
// Scoreboard bench: four configurations share one stimulus stream and are
// checked against a behavioural register-file model.
module tb_vliw_regfile;
  import vliw_regfile_pkg::*;

  localparam cvw_t P32  = '{XLEN: 32, E_SUPPORTED: 1'b0};
  localparam cvw_t P32E = '{XLEN: 32, E_SUPPORTED: 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [3:0]           we3;
  logic [3:0][4:0]      a3, a1, a2;
  logic [3:0][31:0]     wd3;

  logic [3:0][31:0]     rd1_o [4];
  logic [3:0][31:0]     rd2_o [4];
  logic [3:0]           wc_o, st_o;
  logic [15:0]          cnt0, cnt1, cnt3;
  logic [3:0]           cnt2;

  // cfg0: bypass, cfg1: no bypass, cfg2: 4-bit counter, cfg3: RV32E
  vliw_regfile #(.P(P32), .LANES(4), .BYPASS(1'b1), .CNTW(16)) dut0 (
    .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .a2(a2),
    .rd1(rd1_o[0]), .rd2(rd2_o[0]), .WriteCollisionM(wc_o[0]),
    .CollisionSticky(st_o[0]), .CollisionCount(cnt0));
  vliw_regfile #(.P(P32), .LANES(4), .BYPASS(1'b0), .CNTW(16)) dut1 (
    .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .a2(a2),
    .rd1(rd1_o[1]), .rd2(rd2_o[1]), .WriteCollisionM(wc_o[1]),
    .CollisionSticky(st_o[1]), .CollisionCount(cnt1));
  vliw_regfile #(.P(P32), .LANES(4), .BYPASS(1'b1), .CNTW(4)) dut2 (
    .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .a2(a2),
    .rd1(rd1_o[2]), .rd2(rd2_o[2]), .WriteCollisionM(wc_o[2]),
    .CollisionSticky(st_o[2]), .CollisionCount(cnt2));
  vliw_regfile #(.P(P32E), .LANES(4), .BYPASS(1'b1), .CNTW(16)) dut3 (
    .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .a2(a2),
    .rd1(rd1_o[3]), .rd2(rd2_o[3]), .WriteCollisionM(wc_o[3]),
    .CollisionSticky(st_o[3]), .CollisionCount(cnt3));

  logic [3:0][15:0] act_cnt;
  assign act_cnt = {cnt3, {12'b0, cnt2}, cnt1, cnt0};

  // Reference model
  bit          cfg_byp [4] = '{1, 0, 1, 1};
  int unsigned cfg_max [4] = '{65535, 65535, 15, 65535};
  int unsigned cfg_nreg[4] = '{32, 32, 32, 16};
  logic [31:0] mregs [4][32];
  bit          mwc [4], mst [4];
  int unsigned mcnt [4];
  bit          mvalid = 1'b0;
  logic [31:0] pend_d [32];
  bit          pend_v [32];

  typedef struct packed {
    logic             chk;
    logic [3:0][3:0][31:0] rd1;
    logic [3:0][3:0][31:0] rd2;
    logic [3:0]       wc;
    logic [3:0]       st;
    logic [3:0][15:0] cnt;
  } exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [31:0] model_read(input int c, input logic [4:0] a);
    if (reset || a == 0 || int'(a) >= int'(cfg_nreg[c])) return 32'h0;
    if (cfg_byp[c] && pend_v[a]) return pend_d[a];
    return mregs[c][a];
  endfunction

  task automatic push_expect();
    exp_t e;
    int   hits [32];
    bit   coll;
    e = '0;
    e.chk = mvalid;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 32; r++) begin
        hits[r] = 0; pend_v[r] = 1'b0; pend_d[r] = '0;
      end
      // bundle order: later lanes overwrite earlier ones
      for (int i = 0; i < 4; i++) begin
        if (we3[i] && a3[i] != 0 && int'(a3[i]) < int'(cfg_nreg[c])) begin
          hits[a3[i]]++;
          pend_v[a3[i]] = 1'b1;
          pend_d[a3[i]] = wd3[i];
        end
      end
      coll = 1'b0;
      for (int r = 0; r < 32; r++) if (hits[r] > 1) coll = 1'b1;
      for (int i = 0; i < 4; i++) begin
        e.rd1[c][i] = model_read(c, a1[i]);
        e.rd2[c][i] = model_read(c, a2[i]);
      end
      e.wc[c]  = mwc[c];
      e.st[c]  = mst[c];
      e.cnt[c] = 16'(mcnt[c]);
      if (reset) begin
        for (int r = 0; r < 32; r++) mregs[c][r] = '0;
        mwc[c] = 1'b0; mst[c] = 1'b0; mcnt[c] = 0;
      end else begin
        for (int r = 0; r < 32; r++) if (pend_v[r]) mregs[c][r] = pend_d[r];
        mwc[c] = coll;
        if (coll) begin
          mst[c] = 1'b1;
          if (mcnt[c] < cfg_max[c]) mcnt[c]++;
        end
      end
    end
    if (reset) mvalid = 1'b1;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle; sample mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      for (int c = 0; c < 4; c++) begin
        for (int i = 0; i < 4; i++) begin
          check($sformatf("cfg%0d rd1[%0d]", c, i), rd1_o[c][i], e.rd1[c][i]);
          check($sformatf("cfg%0d rd2[%0d]", c, i), rd2_o[c][i], e.rd2[c][i]);
        end
        if (e.chk) begin
          check($sformatf("cfg%0d WriteCollisionM", c), 32'(wc_o[c]), 32'(e.wc[c]));
          check($sformatf("cfg%0d CollisionSticky", c), 32'(st_o[c]), 32'(e.st[c]));
          check($sformatf("cfg%0d CollisionCount", c), 32'(act_cnt[c]), 32'(e.cnt[c]));
        end
      end
    end
  end

  task automatic tick();
    push_expect();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = '0; a3 = '0; wd3 = '0;
  endtask

  initial begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 32; r++) mregs[c][r] = '0;
      mwc[c] = 1'b0; mst[c] = 1'b0; mcnt[c] = 0;
    end
    reset = 1'b1; idle(); a1 = '0; a2 = '0;
    @(posedge clk);
    #1;
    // reset with conflicting writes to x5 on every lane
    we3 = 4'b1111; a3 = {4{5'd5}}; wd3 = {4{32'hFFFF_FFFF}}; a1 = {4{5'd5}};
    tick(); tick();
    reset = 1'b0; idle();
    tick();
    // basic write/read
    we3 = 4'b0101; a3[2] = 5'd7; wd3[2] = 32'h1234; a3[0] = 5'd9; wd3[0] = 32'hABCD;
    a1[3] = 5'd7; a2[3] = 5'd9;
    tick();
    idle(); we3[1] = 1'b1; a3[1] = 5'd0; wd3[1] = 32'hFF; a1[2] = 5'd0; a2[2] = 5'd0;
    tick();
    // bypass of a same-cycle write
    idle(); we3[1] = 1'b1; a3[1] = 5'd10; wd3[1] = 32'h55; a1[0] = 5'd10;
    tick();
    idle();
    tick();
    // three-lane collision on x12
    we3 = 4'b1011; a3[0] = 5'd12; a3[1] = 5'd12; a3[3] = 5'd12;
    wd3[0] = 32'h1; wd3[1] = 32'h2; wd3[3] = 32'h3; a1[1] = 5'd12;
    tick();
    idle();
    repeat (3) tick();
    // 20 consecutive collision cycles for counter saturation
    for (int k = 0; k < 20; k++) begin
      we3 = 4'b0011; a3[0] = 5'd3; a3[1] = 5'd3;
      wd3[0] = $urandom; wd3[1] = $urandom; a2[0] = 5'd3;
      tick();
    end
    idle();
    tick();
    // x20 written by two lanes: beyond the RV32E register range
    we3 = 4'b1001; a3[0] = 5'd20; a3[3] = 5'd20; wd3[0] = 32'h99; wd3[3] = 32'h99;
    a1 = {4{5'd20}};
    tick();
    idle();
    tick();
    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 49) == 0);
      we3 = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        a3[i]  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        wd3[i] = $urandom;
        a1[i]  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
        a2[i]  = 5'($urandom);
      end
      tick();
    end
    reset = 1'b0; idle();
    repeat (3) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
